// File: rtl/dnn_pkg.sv
// Shared DNN accelerator definitions: loader FSM states and the on-chip memory map.
package dnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Region base addresses in the 17-bit parameter memory.
  localparam logic [16:0] ADDR_BASE_A      = 17'h00000;
  localparam logic [16:0] ADDR_BASE_W      = 17'h00191;
  localparam logic [16:0] ADDR_BASE_LUT_L1 = 17'h029BE;
  localparam logic [16:0] ADDR_BASE_LUT_L2 = 17'h0A9BE;

  // Layer-2 constant-one bias input, 1.0 with 13 fractional bits.
  localparam logic signed [14:0] L2_ONE_BIAS_VAL = 15'sd8192;

endpackage

// File: rtl/dnn_mem_loader_fix15.sv
// Streams words from a valid/ready source into a contiguous memory region,
// checking region bounds and stream length, and keeping a running checksum.
module dnn_mem_loader_fix15
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH = 15,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        load_base,
  input  logic [ADDR_WIDTH-1:0]        load_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic signed [DATA_WIDTH-1:0] mem_data,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [15:0]                  checksum
);

  localparam logic [ADDR_WIDTH:0]   ADDR_SPAN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0]   count_q, count_d;
  logic [15:0]             cks_q, cks_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH:0]     end_addr;
  logic                    xfer;

  assign end_addr = {1'b0, load_base} + {1'b0, load_len};
  assign xfer     = (state_q == ST_LOAD) && in_valid;

  // NOTE: every signal written here gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    count_d = count_q;
    cks_d   = cks_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    if (state_q == ST_LOAD) begin
      if (xfer) begin
        we_d    = 1'b1;
        addr_d  = base_q + count_q;
        data_d  = in_data;
        cks_d   = cks_q + 16'(in_data);
        count_d = count_q + ONE;
        // The final expected word decides the outcome; an earlier last is a short stream.
        if (count_q + ONE == len_q) begin
          state_d = in_last ? ST_DONE : ST_ERR;
        end else if (in_last) begin
          state_d = ST_ERR;
        end
      end
    end else if (start) begin
      base_d  = load_base;
      len_d   = load_len;
      count_d = '0;
      cks_d   = '0;
      if (load_len == '0) begin
        state_d = ST_DONE;
      end else if (end_addr > ADDR_SPAN) begin
        state_d = ST_ERR;
      end else begin
        state_d = ST_LOAD;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments; every register, including
  // the write pipeline, is cleared by reset so an in-flight write is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      cks_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      count_q <= count_d;
      cks_q   <= cks_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Terminal flags wait for the trailing write so the checksum is final when they rise.
  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_LOAD) || we_q;
  assign done     = (state_q == ST_DONE) && !we_q;
  assign error    = (state_q == ST_ERR)  && !we_q;
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign checksum = cks_q;

endmodule

// File: tb/tb_dnn_mem_loader_fix15.sv
// Randomized and directed bench for dnn_mem_loader_fix15 against a transaction-level model.
module tb_dnn_mem_loader_fix15;

  localparam int DW = 15;
  localparam int AW = 17;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [AW-1:0]        load_base = '0;
  logic [AW-1:0]        load_len = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_last = 1'b0;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic signed [DW-1:0] mem_data;
  logic                 busy, done, error;
  logic [15:0]          checksum;

  dnn_mem_loader_fix15 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .load_base(load_base), .load_len(load_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed writes, sampled on the falling edge.
  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];
  int            wq_cyc[$];

  always @(negedge clk) begin
    if (mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_data);
      wq_cyc.push_back(cyc);
    end
  end

  // Stream to present for the next load.
  logic [DW-1:0] s_data[$];
  bit            s_last[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_we"},    32'(mem_we), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_data"},  32'(unsigned'(mem_data)), 32'd0);
    check({tag, "_cks"},   32'(checksum), 32'd0);
  endtask

  // vmode: 0 valid always high, 1 alternating starting high, 2 random.
  task automatic run_load(input string tag, input int base, input int len,
                          input int vmode, input bit mid_start);
    logic [AW-1:0] e_addr[$];
    logic [DW-1:0] e_data[$];
    int            xq[$];
    bit            e_done = 0;
    bit            e_err = 0;
    bit            e_streams = 0;
    int            cks = 0;
    int            idx = 0;
    int            step = 0;
    int            budget;
    bit            v;
    bit            mid_done = 0;

    // Reference: what a load of this stream must write and how it must end.
    if (len == 0) begin
      e_done = 1;
    end else if (base + len > (1 << AW)) begin
      e_err = 1;
    end else begin
      e_streams = 1;
      for (int i = 0; i < s_data.size(); i++) begin
        e_addr.push_back(AW'(base + i));
        e_data.push_back(s_data[i]);
        cks += int'(signed'(s_data[i]));
        if (i == len - 1) begin
          e_done = s_last[i];
          e_err  = !s_last[i];
          break;
        end
        if (s_last[i]) begin
          e_err = 1;
          break;
        end
      end
    end

    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    @(negedge clk);
    start = 1'b1; load_base = AW'(base); load_len = AW'(len);
    @(negedge clk);
    start = 1'b0;
    if (!e_streams) begin
      check({tag, "_fast_done"},  32'(done), 32'(e_done));
      check({tag, "_fast_error"}, 32'(error), 32'(e_err));
    end

    while (e_streams && in_ready && idx < s_data.size() && step < 300) begin
      start = 1'b0;
      if (mid_start && !mid_done && idx == 1) begin
        start = 1'b1; load_base = AW'(base ^ 'h40); load_len = AW'(2);
        mid_done = 1;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (step % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v; in_data = s_data[idx]; in_last = s_last[idx];
      if (v) begin
        xq.push_back(cyc + 1);
        idx++;
      end
      step++;
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;

    budget = 0;
    while (busy && budget < 20) begin
      budget++;
      @(negedge clk);
    end
    check({tag, "_settle"}, 32'(busy), 32'd0);

    check({tag, "_done"},   32'(done), 32'(e_done));
    check({tag, "_error"},  32'(error), 32'(e_err));
    check({tag, "_ready"},  32'(in_ready), 32'd0);
    check({tag, "_cks"},    32'(checksum), 32'(cks & 'hFFFF));
    check({tag, "_nwr"},    32'(wq_addr.size()), 32'(e_addr.size()));
    for (int i = 0; i < e_addr.size() && i < wq_addr.size(); i++) begin
      check({tag, $sformatf("_addr%0d", i)}, 32'(wq_addr[i]), 32'(e_addr[i]));
      check({tag, $sformatf("_data%0d", i)}, 32'(wq_data[i]), 32'(e_data[i]));
      if (i < xq.size())
        check({tag, $sformatf("_lat%0d", i)}, 32'(wq_cyc[i]), 32'(xq[i]));
    end
    if (vmode == 0 && wq_cyc.size() > 1)
      check({tag, "_nobubble"}, 32'(wq_cyc[wq_cyc.size()-1] - wq_cyc[0]),
            32'(wq_cyc.size() - 1));
  endtask

  task automatic set_stream(input int n, input int last_at);
    s_data.delete(); s_last.delete();
    for (int i = 0; i < n; i++) begin
      s_data.push_back(DW'($urandom));
      s_last.push_back(i == last_at);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int len, base, kind, last_at;

    // Outputs while reset is held.
    #12;
    check_idle_outputs("reset");
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd0);

    // Weights region, always-valid stream 1,2,-1,3.
    s_data = '{15'd1, 15'd2, 15'h7FFF, 15'd3};
    s_last = '{0, 0, 0, 1};
    run_load("w_region", 'h0191, 4, 0, 0);

    // LUT L1 region with valid toggling.
    set_stream(3, 2);
    run_load("toggle", 'h29BE, 3, 1, 0);

    // Short stream: last on word 2 of 3.
    set_stream(3, 1);
    run_load("short", 'h0400, 3, 0, 0);

    // Region past the end of memory, then an empty load.
    set_stream(3, 2);
    run_load("overflow", 'h1FFFE, 3, 0, 0);
    s_data.delete(); s_last.delete();
    run_load("empty", 'h0100, 0, 0, 0);

    // Region ending exactly at the top of memory is legal.
    set_stream(2, 1);
    run_load("top_edge", 'h1FFFE, 2, 0, 0);

    // Missing last on the final word.
    set_stream(3, -1);
    run_load("no_last", 'h0010, 3, 0, 0);

    // Start pulsed mid-load is ignored.
    set_stream(5, 4);
    run_load("mid_start", 'h0A9BE, 5, 0, 1);

    // Reset after two of five words, with the second write in flight.
    @(negedge clk);
    start = 1'b1; load_base = AW'('h0300); load_len = AW'(5);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 15'd7; in_last = 1'b0;
    @(negedge clk);
    in_data = 15'd9;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(negedge clk); rst = 1'b1;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    repeat (3) @(negedge clk);
    check("abort_nowrite", 32'(wq_addr.size()), 32'd0);
    check("abort_ready",   32'(in_ready), 32'd0);
    set_stream(3, 2);
    run_load("after_abort", 'h0500, 3, 0, 0);

    // Randomized loads.
    for (int t = 0; t < 40; t++) begin
      len  = $urandom_range(0, 8);
      base = ($urandom_range(0, 5) == 0) ? (1 << AW) - $urandom_range(1, 10)
                                         : $urandom_range(0, (1 << AW) - 9);
      kind = $urandom_range(0, 3);
      case (kind)
        1:       last_at = -1;
        2:       last_at = (len > 0) ? $urandom_range(0, len - 1) : 0;
        default: last_at = len - 1;
      endcase
      set_stream((len == 0) ? 1 : len, last_at);
      run_load($sformatf("rnd%0d", t), base, len, $urandom_range(0, 2),
               (len >= 3) && ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
